// File: rtl/tick_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_pkg
// Brief    : Shared mode type and default sizing for the tick/tone generator.
// Revision : 1.0
// ============================================================================
package tick_gen_pkg;

  typedef enum logic {MODE_PULSE, MODE_SQUARE} tick_mode_t;

  localparam int c_def_width = 16;
  localparam int c_def_nch   = 4;

endpackage
`default_nettype wire

// File: rtl/tick_chan.sv
`default_nettype none
// ============================================================================
// Module   : tick_chan
// Brief    : One tick/tone channel: counter, shadowed limit/mode, outputs.
// Revision : 1.0
// ============================================================================
module tick_chan
  import tick_gen_pkg::*;
#(
  parameter int WIDTH = c_def_width
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             en,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] lim,
  input  tick_mode_t       mode,
  output logic             tick,
  output logic             wave,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_lim_a;
  logic [WIDTH-1:0] r_lim_s;
  tick_mode_t       r_mode_a;
  tick_mode_t       r_mode_s;
  logic             r_pend;
  logic             r_tick;
  logic             r_wave;

  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_lim_a_nxt;
  logic [WIDTH-1:0] w_lim_s_nxt;
  tick_mode_t       w_mode_a_nxt;
  tick_mode_t       w_mode_s_nxt;
  logic             w_pend_nxt;
  logic             w_tick_nxt;
  logic             w_wave_nxt;
  logic             w_wrap;

  // >= rather than == so a limit lowered below cnt recovers in one cycle
  assign w_wrap = en && (r_cnt >= r_lim_a);

  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_lim_a_nxt  = r_lim_a;
    w_lim_s_nxt  = r_lim_s;
    w_mode_a_nxt = r_mode_a;
    w_mode_s_nxt = r_mode_s;
    w_pend_nxt   = r_pend;
    w_tick_nxt   = 1'b0;
    w_wave_nxt   = r_wave;

    if (clr) begin
      w_cnt_nxt  = '0;
      w_wave_nxt = 1'b0;
      if (wr) begin
        w_lim_a_nxt  = lim;
        w_mode_a_nxt = mode;
        w_lim_s_nxt  = lim;
        w_mode_s_nxt = mode;
        w_pend_nxt   = 1'b0;
      end else if (r_pend) begin
        w_lim_a_nxt  = r_lim_s;
        w_mode_a_nxt = r_mode_s;
        w_pend_nxt   = 1'b0;
      end
    end else begin
      if (w_wrap) begin
        w_cnt_nxt  = '0;
        w_tick_nxt = 1'b1;
        // A pending switch to pulse lands with wave already mirroring tick
        if ((r_mode_a == MODE_PULSE) || (r_pend && (r_mode_s == MODE_PULSE)))
          w_wave_nxt = 1'b1;
        else
          w_wave_nxt = ~r_wave;
        if (r_pend) begin
          w_lim_a_nxt  = r_lim_s;
          w_mode_a_nxt = r_mode_s;
          w_pend_nxt   = 1'b0;
        end
      end else if (en) begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_mode_a == MODE_PULSE)
          w_wave_nxt = 1'b0;
      end

      if (wr) begin
        w_lim_s_nxt  = lim;
        w_mode_s_nxt = mode;
        if (en) begin
          w_pend_nxt = 1'b1;
        end else begin
          w_lim_a_nxt  = lim;
          w_mode_a_nxt = mode;
          w_pend_nxt   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt    <= '0;
      r_lim_a  <= '0;
      r_lim_s  <= '0;
      r_mode_a <= MODE_PULSE;
      r_mode_s <= MODE_PULSE;
      r_pend   <= 1'b0;
      r_tick   <= 1'b0;
      r_wave   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_lim_a  <= w_lim_a_nxt;
      r_lim_s  <= w_lim_s_nxt;
      r_mode_a <= w_mode_a_nxt;
      r_mode_s <= w_mode_s_nxt;
      r_pend   <= w_pend_nxt;
      r_tick   <= w_tick_nxt;
      r_wave   <= w_wave_nxt;
    end
  end

  assign tick = r_tick;
  assign wave = r_wave;
  assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/tick_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen_multi
// Brief    : NCH independent programmable tick/tone channels with readback.
// Revision : 1.0
// ============================================================================
module tick_gen_multi
  import tick_gen_pkg::*;
#(
  parameter int WIDTH = c_def_width,
  parameter int NCH   = c_def_nch,
  parameter int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_lim,
  input  logic             wr_mode,
  input  logic [CHW-1:0]   rd_ch,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   wave,
  output logic [WIDTH-1:0] rd_cnt
);

  logic [WIDTH-1:0] w_cnt [NCH];
  logic [NCH-1:0]   w_wr;

  // Out-of-range wr_ch matches no channel and is silently dropped
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign w_wr[gi] = wr_en && (wr_ch == CHW'(gi));

    tick_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk   (clk),
      .n_rst (n_rst),
      .en    (ch_en[gi]),
      .clr   (sync_clr),
      .wr    (w_wr[gi]),
      .lim   (wr_lim),
      .mode  (tick_mode_t'(wr_mode)),
      .tick  (tick[gi]),
      .wave  (wave[gi]),
      .cnt   (w_cnt[gi])
    );
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch == CHW'(i))
        rd_cnt = w_cnt[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tick_gen_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_tick_gen_multi
// Brief    : Directed + randomized bench for tick_gen_multi against a model.
// Revision : 1.0
// ============================================================================
module tb_tick_gen_multi;

  localparam int WIDTH = 8;
  localparam int NCH   = 3;
  localparam int CHW   = 2;

  logic             clk;
  logic             n_rst;
  logic [NCH-1:0]   ch_en;
  logic             sync_clr;
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_lim;
  logic             wr_mode;
  logic [CHW-1:0]   rd_ch;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   wave;
  logic [WIDTH-1:0] rd_cnt;

  tick_gen_multi #(
    .WIDTH (WIDTH),
    .NCH   (NCH),
    .CHW   (CHW)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_lim   (wr_lim),
    .wr_mode  (wr_mode),
    .rd_ch    (rd_ch),
    .tick     (tick),
    .wave     (wave),
    .rd_cnt   (rd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: per-channel state as the spec describes it (mode 0 = pulse)
  int unsigned m_cnt  [NCH];
  int unsigned m_lima [NCH];
  int unsigned m_lims [NCH];
  bit          m_modea[NCH];
  bit          m_modes[NCH];
  bit          m_pend [NCH];
  bit          m_tick [NCH];
  bit          m_wave [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0;  m_lima[c] = 0; m_lims[c] = 0;
      m_modea[c] = 0; m_modes[c] = 0; m_pend[c] = 0;
      m_tick[c] = 0; m_wave[c] = 0;
    end
  endtask

  task automatic model_clock();
    if (!n_rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NCH; c++) begin
      bit hit;
      hit = wr_en && (int'(wr_ch) == c);
      if (sync_clr) begin
        if (hit) begin
          m_lima[c] = wr_lim; m_modea[c] = wr_mode;
          m_lims[c] = wr_lim; m_modes[c] = wr_mode;
          m_pend[c] = 0;
        end else if (m_pend[c]) begin
          m_lima[c] = m_lims[c]; m_modea[c] = m_modes[c]; m_pend[c] = 0;
        end
        m_cnt[c] = 0; m_tick[c] = 0; m_wave[c] = 0;
      end else if (ch_en[c]) begin
        if (m_cnt[c] >= m_lima[c]) begin
          m_tick[c] = 1;
          if (!m_modea[c] || (m_pend[c] && !m_modes[c])) m_wave[c] = 1;
          else m_wave[c] = !m_wave[c];
          m_cnt[c] = 0;
          if (m_pend[c]) begin
            m_lima[c] = m_lims[c]; m_modea[c] = m_modes[c]; m_pend[c] = 0;
          end
        end else begin
          m_cnt[c] = m_cnt[c] + 1;
          m_tick[c] = 0;
          if (!m_modea[c]) m_wave[c] = 0;
        end
        if (hit) begin
          m_lims[c] = wr_lim; m_modes[c] = wr_mode; m_pend[c] = 1;
        end
      end else begin
        m_tick[c] = 0;
        if (hit) begin
          m_lima[c] = wr_lim; m_modea[c] = wr_mode;
          m_lims[c] = wr_lim; m_modes[c] = wr_mode;
          m_pend[c] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [NCH-1:0] et, ew;
    int unsigned    ec;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c];
      ew[c] = m_wave[c];
    end
    ec = 0;
    if (int'(rd_ch) < NCH) ec = m_cnt[rd_ch];
    check("tick", tick, et);
    check("wave", wave, ew);
    check("rd_cnt", rd_cnt, ec);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_clock();
    #1;
    compare();
  endtask

  task automatic wr(input int ch, input int l, input bit m);
    wr_en = 1'b1; wr_ch = CHW'(ch); wr_lim = WIDTH'(l); wr_mode = m;
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic wait_cnt(input int ch, input int val);
    rd_ch = CHW'(ch);
    for (int k = 0; k < 64 && int'(rd_cnt) != val; k++) cycle();
    check("wait_cnt", rd_cnt, val);
  endtask

  initial begin
    int unsigned held;
    n_rst = 1'b0; ch_en = '0; sync_clr = 1'b0; wr_en = 1'b0;
    wr_ch = '0; wr_lim = '0; wr_mode = 1'b0; rd_ch = '0;
    model_reset();
    #3;
    check("rst_tick", tick, 0);
    check("rst_wave", wave, 0);
    check("rst_cnt", rd_cnt, 0);
    repeat (2) cycle();
    n_rst = 1'b1;

    // ch0 lim=3 pulse while disabled, then ticks at edges 4, 8, 12
    wr(0, 3, 1'b0);
    ch_en = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      check("t0_edge", tick[0], (k % 4) == 0);
      check("t0_wave", wave[0], (k % 4) == 0);
    end

    // ch1 lim=2 square, readback on ch1
    wr(1, 2, 1'b1);
    ch_en = 3'b011;
    rd_ch = 2'd1;
    repeat (12) cycle();

    // ch0 running: change to lim=7, then lim=1 mid-period, then write on a wrap
    wr(0, 7, 1'b0);
    wait_cnt(0, 7);
    wait_cnt(0, 2);
    wr(0, 1, 1'b0);
    repeat (12) cycle();
    wait_cnt(0, 1);
    wr(0, 4, 1'b0);
    repeat (10) cycle();

    // last write wins; out-of-range channel ignored
    wait_cnt(0, 0);
    wr(0, 5, 1'b0);
    wr(0, 9, 1'b0);
    wr(3, 200, 1'b1);
    repeat (30) cycle();

    // staggered channels, pending shadows, then sync clear
    ch_en = 3'b111;
    repeat (5) cycle();
    wr(0, 3, 1'b0);
    wr(2, 3, 1'b0);
    sync_clr = 1'b1;
    rd_ch = 2'd0;
    cycle();
    sync_clr = 1'b0;
    check("clr_tick", tick, 0);
    check("clr_wave", wave, 0);
    check("clr_cnt", rd_cnt, 0);
    for (int k = 1; k <= 8; k++) begin
      cycle();
      check("clr_t0", tick[0], (k % 4) == 0);
      check("clr_t2", tick[2], (k % 4) == 0);
    end

    // lim=0 pulse on ch1: tick stays high
    wr(1, 0, 1'b0);
    repeat (4) cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("lim0_tick", tick[1], 1);
    end

    // disable ch0 mid-count for 10 cycles, then resume
    wait_cnt(0, 2);
    ch_en[0] = 1'b0;
    cycle();
    held = m_cnt[0];
    repeat (10) cycle();
    check("hold_cnt", rd_cnt, held);
    ch_en[0] = 1'b1;
    repeat (8) cycle();

    // randomized traffic with one asynchronous reset mid-run
    for (int i = 0; i < 3000; i++) begin
      int r;
      wr_en = ($urandom_range(0, 5) == 0);
      wr_ch = CHW'($urandom_range(0, 3));
      wr_lim = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom_range(0, 255))
                                           : WIDTH'($urandom_range(0, 7));
      wr_mode = $urandom_range(0, 1) == 1;
      sync_clr = ($urandom_range(0, 99) == 0);
      rd_ch = CHW'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, NCH - 1);
        ch_en[r] = ~ch_en[r];
      end
      if (i == 1500) begin
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_tick", tick, 0);
        check("arst_wave", wave, 0);
        check("arst_cnt", rd_cnt, 0);
        model_reset();
        cycle();
        n_rst = 1'b1;
      end else begin
        cycle();
      end
    end
    wr_en = 1'b0;
    sync_clr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
